fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 32, shall set the datapath width of instruction and PC values.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, shall be the first fetch address after reset.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  shall be the asynchronous, active-high reset.
REQ-005 stallF  input  1  shall mean decode cannot accept; the fetch/decode register holds.
REQ-006 flushD  input  1  shall mean the fetch/decode register is loaded with a bubble next edge.
REQ-007 branchTaken  input  1  shall request a PC redirect to branchTarget.
REQ-008 branchTarget  input  N  shall be the redirect address.
REQ-009 imem_req  output  1  shall request an instruction read at imem_addr.
REQ-010 imem_addr  output  N  shall be the fetch address, stable while imem_req=1 and imem_ack=0.
REQ-011 imem_rdata  input  N  shall be the instruction word, valid when imem_ack=1.
REQ-012 imem_ack  input  1  shall complete the outstanding read; legal in the same cycle as imem_req (zero wait) or any later cycle.
REQ-013 inst_fd  output  N  shall be the instruction presented to the decode stage.
REQ-014 pc_fd  output  N  shall be the fetch address of inst_fd plus 8 (R15 read value).
REQ-015 valid_fd  output  1  shall mark inst_fd/pc_fd as a real instruction.

Function
REQ-016 States shall be REQ (imem_req=1, imem_addr=pc_q), HOLD (imem_req=0, fetched word parked in a one-entry skid buffer), DRAIN (imem_req=1 on the stale address, awaiting an ack to discard).
REQ-017 In REQ with imem_ack=1 and stallF=0: inst_fd<=imem_rdata, pc_fd<=pc_q+8, valid_fd<=1, pc_q<=pc_q+4, remain in REQ.
REQ-018 In REQ with imem_ack=1 and stallF=1: skid<=imem_rdata, skid_pc<=pc_q, fetch/decode register unchanged, go HOLD.
REQ-019 In REQ with imem_ack=0 and stallF=0: fetch/decode register shall load a bubble (valid_fd=0, inst_fd=0, pc_fd=0).
REQ-020 In HOLD with stallF=0: inst_fd<=skid, pc_fd<=skid_pc+8, valid_fd<=1, pc_q<=skid_pc+4, go REQ; with stallF=1, remain in HOLD.
REQ-021 stallF=1 outside the cases above shall hold inst_fd, pc_fd and valid_fd unchanged.
REQ-022 branchTaken=1 shall set pc_q<=branchTarget with bits [1:0] forced to 0 and load a bubble into the fetch/decode register, regardless of stallF.
REQ-023 branchTaken in REQ without ack shall go DRAIN; the next ack shall be discarded, then go REQ on the new pc_q; with ack in the same cycle, the word is discarded and the state goes REQ.
REQ-024 branchTaken in HOLD shall drop the skid entry and go REQ.
REQ-025 branchTaken in DRAIN shall update pc_q and remain in DRAIN.
REQ-026 flushD=1 without branchTaken shall load a bubble and override stallF; fetch state and pc_q proceed as if stallF=0.
REQ-027 Priority shall be rst > branchTaken > flushD > stallF.
REQ-028 PC arithmetic shall be modulo 2^N; 32'hFFFF_FFFC+4 shall wrap to 0.
REQ-029 No instruction shall be lost or duplicated across any stall, flush or ack-latency combination except those explicitly discarded by REQ-022..REQ-026.

Reset
REQ-030 While rst=1: pc_q=RESET_PC, state=REQ, inst_fd=0, pc_fd=0, valid_fd=0, skid cleared, discard flag cleared; imem_req shall be 0 during reset.
REQ-031 First edge after rst deasserts shall see imem_req=1, imem_addr=RESET_PC.
REQ-032 rst asserted mid-request shall abandon the read; a late ack after reset deassertion without a new request shall be ignored.

Verification
REQ-033 Zero-wait memory, no stalls, imem[0]=A, imem[4]=B -> valid_fd=1 on consecutive cycles with (A, pc_fd=8), (B, pc_fd=12).
REQ-034 Ack latency 3 cycles -> two bubble cycles (valid_fd=0) between instructions; imem_addr stable for the whole wait.
REQ-035 stallF=1 for 4 cycles while the ack for addr 0x10 arrives -> HOLD entered, inst_fd unchanged during the stall, word at 0x10 emitted after release, next imem_addr=0x14.
REQ-036 branchTaken with target 0x103 while the read at 0x20 is pending -> that ack is discarded, next imem_addr=0x100, and the 0x20 word never appears on valid_fd.
REQ-037 flushD and stallF both asserted -> valid_fd=0, inst_fd=0 next cycle.
REQ-038 RESET_PC=32'hFFFF_FFFC, zero-wait memory -> second fetch address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding imem read, one-entry skid buffer
// for stalls, and a drain state that discards the reply to a redirected read.
module fetch_stage #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stallF,
    input  logic         flushD,
    input  logic         branchTaken,
    input  logic [N-1:0] branchTarget,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         imem_ack,
    output logic [N-1:0] inst_fd,
    output logic [N-1:0] pc_fd,
    output logic         valid_fd
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;

    state_t       r_state, w_state_n;
    logic [N-1:0] r_pc, w_pc_n;
    logic [N-1:0] r_stale, w_stale_n;
    logic [N-1:0] r_skid, w_skid_n;
    logic [N-1:0] r_skid_pc, w_skid_pc_n;
    logic [N-1:0] r_inst, w_inst_n;
    logic [N-1:0] r_pcfd, w_pcfd_n;
    logic         r_valid, w_valid_n;

    logic [N-1:0] w_tgt;
    logic         w_hold;

    assign w_tgt  = branchTarget & ~N'(3);
    // flushD overrides stallF, so decode only holds on a stall without flush
    assign w_hold = stallF && !flushD;

    assign imem_req  = !rst && (r_state != S_HOLD);
    assign imem_addr = (r_state == S_DRAIN) ? r_stale : r_pc;
    assign inst_fd   = r_inst;
    assign pc_fd     = r_pcfd;
    assign valid_fd  = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_stale   <= '0;
            r_skid    <= '0;
            r_skid_pc <= '0;
            r_inst    <= '0;
            r_pcfd    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pc      <= w_pc_n;
            r_stale   <= w_stale_n;
            r_skid    <= w_skid_n;
            r_skid_pc <= w_skid_pc_n;
            r_inst    <= w_inst_n;
            r_pcfd    <= w_pcfd_n;
            r_valid   <= w_valid_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_stale_n   = r_stale;
        w_skid_n    = r_skid;
        w_skid_pc_n = r_skid_pc;
        w_inst_n    = r_inst;
        w_pcfd_n    = r_pcfd;
        w_valid_n   = r_valid;

        // Any non-holding cycle that does not deliver a word inserts a bubble
        if (branchTaken || !w_hold) begin
            w_inst_n  = '0;
            w_pcfd_n  = '0;
            w_valid_n = 1'b0;
        end

        unique case (r_state)
            S_REQ: begin
                if (branchTaken) begin
                    w_pc_n = w_tgt;
                    if (!imem_ack) begin
                        w_state_n = S_DRAIN;
                        w_stale_n = r_pc;
                    end
                end else if (imem_ack) begin
                    if (w_hold) begin
                        w_skid_n    = imem_rdata;
                        w_skid_pc_n = r_pc;
                        w_state_n   = S_HOLD;
                    end else begin
                        w_pc_n = r_pc + N'(4);
                        if (!flushD) begin
                            w_inst_n  = imem_rdata;
                            w_pcfd_n  = r_pc + N'(8);
                            w_valid_n = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (branchTaken) begin
                    w_pc_n    = w_tgt;
                    w_skid_n  = '0;
                    w_state_n = S_REQ;
                end else if (!w_hold) begin
                    w_pc_n    = r_skid_pc + N'(4);
                    w_state_n = S_REQ;
                    if (!flushD) begin
                        w_inst_n  = r_skid;
                        w_pcfd_n  = r_skid_pc + N'(8);
                        w_valid_n = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Stale address stays on the bus until its ack is swallowed
                if (branchTaken)
                    w_pc_n = w_tgt;
                if (imem_ack)
                    w_state_n = S_REQ;
            end
            default: w_state_n = S_REQ;
        endcase
    end

endmodule
